console_tx_port: RTL

CONSOLE_TX_PORT -- requirements
Module: console_tx_port

---
 rtl/console_tx_port_pkg.sv | 37 +++
 rtl/console_tx_port_sync_fifo.sv | 66 ++++++
 rtl/console_tx_port.sv | 107 ++++++++++
 3 files changed

// File: rtl/console_tx_port_pkg.sv
// Shared definitions for the console transmit port.
// Holds the register map offsets, the STATUS/CTRL bit positions, the default
// responder base address and a helper that packs the STATUS word.
package console_tx_port_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'hE000_8000;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2,
    REG_RSVD   = 2'd3
  } reg_off_e;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_IRQ_EN    = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 9;

  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_FLUSH  = 1;

  function automatic logic [31:0] pack_status(input logic                    empty,
                                              input logic                    full,
                                              input logic                    irq_en,
                                              input logic [STAT_COUNT_W-1:0] count);
    logic [31:0] s;
    s = '0;
    s[STAT_EMPTY]  = empty;
    s[STAT_FULL]   = full;
    s[STAT_IRQ_EN] = irq_en;
    s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
    return s;
  endfunction

endpackage

// File: rtl/console_tx_port_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head output.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-low reset (pointers/count only)
//   push, wdata    write request and data (ignored when full or flushing)
//   pop            read request (ignored when empty)
//   flush          clears pointers and count; overrides push and pop
//   full, empty    occupancy flags derived from count
//   count          number of stored entries, 0..DEPTH
//   head           entry at the read pointer
module sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/console_tx_port.sv
// console_tx_port: memory-mapped byte transmit port with a stream output.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   addr_i, data_i, sel_i,  processor bus; any nonzero we_i bit is a write,
//   we_i                    otherwise a hit is a read
//   data_o                  registered read data (1-cycle latency)
//   stall_o                 holds the processor on a TXDATA write while full
//   irq_o                   level interrupt: irq_en & empty, registered
//   tx_data_o, tx_valid_o,  byte stream from the FIFO head
//   tx_ready_i
module console_tx_port
  import console_tx_port_pkg::*;
#(
  parameter logic [31:0] BASE  = DEFAULT_BASE,
  parameter int          DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        sel_i,
  input  logic [3:0]  we_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        irq_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                    hit;
  logic                    wr_hit;
  logic                    rd_hit;
  reg_off_e                off;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [CW-1:0]           count;
  logic [STAT_COUNT_W-1:0] count_ext;
  logic                    irq_en;
  logic                    flush_q;
  logic                    ready_q;
  logic [31:0]             rdata;
  logic                    unused_bits;

  assign hit    = sel_i & (addr_i[31:4] == BASE[31:4]);
  assign off    = reg_off_e'(addr_i[3:2]);
  assign wr_hit = hit & (|we_i);
  assign rd_hit = hit & ~(|we_i);

  assign stall_o = wr_hit & (off == REG_TXDATA) & full;
  // ready_q keeps the first post-reset edge from accepting a push.
  assign push    = wr_hit & (off == REG_TXDATA) & ~full & ready_q;
  assign pop     = tx_valid_o & tx_ready_i;

  assign tx_valid_o = ~empty;
  assign count_ext  = STAT_COUNT_W'(count);

  assign unused_bits = ^{data_i[31:8], addr_i[1:0]};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .wdata (data_i[7:0]),
    .pop   (pop),
    .flush (flush_q),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (tx_data_o)
  );

  always_comb begin
    rdata = '0;
    case (off)
      REG_STATUS: rdata = pack_status(empty, full, irq_en, count_ext);
      REG_CTRL:   rdata[CTRL_IRQ_EN] = irq_en;
      default:    rdata = '0;
    endcase
  end

  // The flush request is registered, so the FIFO clears on the edge after
  // the CTRL write; a push or pop presented in that cycle is discarded.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ready_q <= 1'b0;
      irq_en  <= 1'b0;
      flush_q <= 1'b0;
      irq_o   <= 1'b0;
      data_o  <= '0;
    end else begin
      ready_q <= 1'b1;
      flush_q <= wr_hit & (off == REG_CTRL) & data_i[CTRL_FLUSH];
      if (wr_hit && off == REG_CTRL) irq_en <= data_i[CTRL_IRQ_EN];
      irq_o <= irq_en & empty;
      if (rd_hit) data_o <= rdata;
    end
  end

endmodule
